// File: rtl/mem_port_arbiter.sv
//-----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single 32-bit memory port between the instruction-fetch
// requester and the load/store (data) requester. Data has priority; a
// starvation counter forces a fetch grant after STARVE_MAX consecutive
// contended data grants. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT
// cycles) -> RESP, with the acknowledge and read data presented in RESP.
//
// Parameters
//   MEM_LAT     cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_MAX  contended data grants before fetch is forced (1..15)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata  data request, write flag, address, store data
//   d_ack               one-cycle data completion pulse
//   i_req/i_addr        fetch request and address
//   i_ack               one-cycle fetch completion pulse
//   rdata               read data, valid with the ack
//   sel                 address mux select, 1 = data, 0 = fetch
//   mem_en/mem_we       one-cycle memory strobe and write enable
//   mem_addr/mem_wdata  registered memory address and store data
//   mem_rdata           memory read data
//   busy                high whenever an access is in progress
//-----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [3:0] LAT_C  = 4'(MEM_LAT);
   localparam logic [3:0] SMAX_C = 4'(STARVE_MAX);

   state_t     state;
   state_t     state_nx;
   logic [3:0] wcnt;
   logic [3:0] starve;
   logic       wflag;
   logic       grant_d;
   logic       grant_i;

   // Arbitration, only meaningful in IDLE. Data wins a tie unless fetch
   // has been passed over STARVE_MAX times in a row.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state == ST_IDLE) begin
         if (d_req && !(i_req && (starve == SMAX_C))) begin
            grant_d = 1'b1;
         end else if (i_req) begin
            grant_i = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Strobes and acks are decoded straight from the state register so they
   // drop the instant reset forces the state back to IDLE.
   always_comb begin
      state_nx = state;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      d_ack    = 1'b0;
      i_ack    = 1'b0;
      busy     = 1'b1;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (grant_d || grant_i) begin
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_en   = 1'b1;
            mem_we   = wflag;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (wcnt == 4'd1) begin
               state_nx = ST_RESP;
            end
         end
         ST_RESP: begin
            d_ack    = sel;
            i_ack    = ~sel;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         sel       <= 1'b0;
         wflag     <= 1'b0;
         wcnt      <= '0;
         starve    <= '0;
      end else begin
         if (grant_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wflag     <= d_we;
            sel       <= 1'b1;
            if (!i_req) begin
               starve <= '0;
            end else if (starve != SMAX_C) begin
               starve <= starve + 4'd1;
            end
         end else if (grant_i) begin
            mem_addr <= i_addr;
            wflag    <= 1'b0;
            sel      <= 1'b0;
            starve   <= '0;
         end

         if (state == ST_ISSUE) begin
            wcnt <= LAT_C;
         end else if (state == ST_WAIT) begin
            wcnt <= wcnt - 4'd1;
         end

         // Last WAIT cycle is exactly when mem_rdata becomes valid.
         if ((state == ST_WAIT) && (wcnt == 4'd1) && !wflag) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
//-----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters (MEM_LAT = 2 and MEM_LAT = 1, STARVE_MAX = 4) driven by
// independent random requesters that follow the request/ack handshake.
// A timestamp-based transaction model predicts every output each cycle:
// a grant at cycle t0 gives mem_en at t0+1, rdata capture of the
// mem_rdata value present at t0+1+L, and the ack at t0+L+2.
//-----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int NI   = 2;
   localparam int LAT0 = 2;
   localparam int LAT1 = 1;
   localparam int SMAX = 4;

   logic        clk;
   logic        rst_n;
   logic        d_req     [NI];
   logic        d_we      [NI];
   logic [31:0] d_addr    [NI];
   logic [31:0] d_wdata   [NI];
   logic        i_req     [NI];
   logic [31:0] i_addr    [NI];
   logic [31:0] mem_rdata [NI];
   logic        d_ack     [NI];
   logic        i_ack     [NI];
   logic [31:0] rdata     [NI];
   logic        sel       [NI];
   logic        mem_en    [NI];
   logic        mem_we    [NI];
   logic [31:0] mem_addr  [NI];
   logic [31:0] mem_wdata [NI];
   logic        busy      [NI];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // transaction model state
   bit          act     [NI];
   int          t0      [NI];
   bit          gd      [NI];
   bit          gwe     [NI];
   bit          e_sel   [NI];
   logic [31:0] e_addr  [NI];
   logic [31:0] e_wdata [NI];
   logic [31:0] e_rdata [NI];
   int          starve  [NI];
   bit          pd_ack  [NI];
   bit          pi_ack  [NI];

   mem_port_arbiter #(.MEM_LAT(LAT0), .STARVE_MAX(SMAX)) u0 (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_ack(d_ack[0]), .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]),
      .rdata(rdata[0]), .sel(sel[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
      .busy(busy[0])
   );

   mem_port_arbiter #(.MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u1 (
      .clk(clk), .rst_n(rst_n),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_ack(d_ack[1]), .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]),
      .rdata(rdata[1]), .sel(sel[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
      .busy(busy[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input int k, input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL u%0d %s: got %h expected %h at %0t", k, tag, got, exp, $time);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   // mode 0: random, 1: both always request, 2: data only, 3: quiet
   function automatic bit want(input int mode, input bit is_data);
      case (mode)
         0:       return $urandom_range(0, 99) < 40;
         1:       return 1'b1;
         2:       return is_data;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_outs(input int k, input bit en, input bit we, input bit bsy,
                             input bit dk, input bit ik, input bit s,
                             input logic [31:0] a, input logic [31:0] w,
                             input logic [31:0] r);
      chk(k, "mem_en",    32'(mem_en[k]), 32'(en));
      chk(k, "mem_we",    32'(mem_we[k]), 32'(we));
      chk(k, "busy",      32'(busy[k]),   32'(bsy));
      chk(k, "d_ack",     32'(d_ack[k]),  32'(dk));
      chk(k, "i_ack",     32'(i_ack[k]),  32'(ik));
      chk(k, "sel",       32'(sel[k]),    32'(s));
      chk(k, "mem_addr",  mem_addr[k],    a);
      chk(k, "mem_wdata", mem_wdata[k],   w);
      chk(k, "rdata",     rdata[k],       r);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         act[k]     = 1'b0;
         t0[k]      = 0;
         gd[k]      = 1'b0;
         gwe[k]     = 1'b0;
         e_sel[k]   = 1'b0;
         e_addr[k]  = '0;
         e_wdata[k] = '0;
         e_rdata[k] = '0;
         starve[k]  = 0;
         pd_ack[k]  = 1'b0;
         pi_ack[k]  = 1'b0;
         d_req[k]   = 1'b0;
         d_we[k]    = 1'b0;
         d_addr[k]  = '0;
         d_wdata[k] = '0;
         i_req[k]   = 1'b0;
         i_addr[k]  = '0;
         mem_rdata[k] = '0;
      end
   endtask

   // Called #1 after a rising edge: check this cycle's outputs, set this
   // cycle's inputs, then advance the model over the coming edge.
   task automatic do_cycle(input int mode);
      for (int k = 0; k < NI; k++) begin
         int L;
         int o;
         bit en;
         bit dk;
         bit ik;
         bit take_d;
         L  = lat_of(k);
         o  = cyc - t0[k];
         en = act[k] && (o == 1);
         dk = act[k] && (o == L + 2) && gd[k];
         ik = act[k] && (o == L + 2) && !gd[k];
         check_outs(k, en, en && gwe[k], act[k], dk, ik, e_sel[k],
                    e_addr[k], e_wdata[k], e_rdata[k]);

         if (!d_req[k] || pd_ack[k]) begin
            if (want(mode, 1'b1)) begin
               d_req[k]   = 1'b1;
               d_we[k]    = 1'($urandom_range(0, 1));
               d_addr[k]  = $urandom;
               d_wdata[k] = $urandom;
            end else begin
               d_req[k] = 1'b0;
            end
         end
         if (!i_req[k] || pi_ack[k]) begin
            if (want(mode, 1'b0)) begin
               i_req[k]  = 1'b1;
               i_addr[k] = $urandom;
            end else begin
               i_req[k] = 1'b0;
            end
         end
         mem_rdata[k] = $urandom;

         if (act[k]) begin
            if ((o == L + 1) && !gwe[k]) e_rdata[k] = mem_rdata[k];
            if (o == L + 2) act[k] = 1'b0;
         end else if (d_req[k] || i_req[k]) begin
            take_d   = d_req[k] && !(i_req[k] && (starve[k] == SMAX));
            act[k]   = 1'b1;
            t0[k]    = cyc;
            gd[k]    = take_d;
            e_sel[k] = take_d;
            if (take_d) begin
               e_addr[k]  = d_addr[k];
               e_wdata[k] = d_wdata[k];
               gwe[k]     = d_we[k];
               if (i_req[k]) starve[k] = (starve[k] < SMAX) ? starve[k] + 1 : SMAX;
               else          starve[k] = 0;
            end else begin
               e_addr[k] = i_addr[k];
               gwe[k]    = 1'b0;
               starve[k] = 0;
            end
         end
         pd_ack[k] = dk;
         pi_ack[k] = ik;
      end
   endtask

   task automatic run(input int mode, input int n);
      for (int i = 0; i < n; i++) begin
         do_cycle(mode);
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      model_reset();
      #12;
      for (int k = 0; k < NI; k++) check_outs(k, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(0, 300);
      run(2, 40);
      run(1, 80);

      // Reset in the first WAIT cycle of unit 0.
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (act[0] && (cyc - t0[0] == 2)) begin
            found = 1'b1;
            break;
         end
         do_cycle(1);
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(0, "reach_wait", 32'(found), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) check_outs(k, 0, 0, 0, 0, 0, 0, '0, '0, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;

      run(0, 300);
      run(1, 40);
      run(3, 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 32-bit memory port of the MiniRISC core between the instruction-fetch requester and the load/store (data) requester. It arbitrates, registers the winning address/data, drives the 32-bit address mux select, sequences a fixed-latency memory access and returns read data with a one-cycle acknowledge. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface

- MEM_LAT, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1–15.
- STARVE_MAX, 4, consecutive data grants made while `i_req` is high before fetch is forced to win; legal range 1–15.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d_req  in  1  data access request; held high until `d_ack`.
- d_we  in  1  1 = store, 0 = load; stable while `d_req` is high.
- d_addr  in  32  data address; stable while `d_req` is high.
- d_wdata  in  32  store data; stable while `d_req` is high.
- d_ack  out  1  one-cycle pulse, data access complete.
- i_req  in  1  fetch request; held high until `i_ack`.
- i_addr  in  32  fetch address (PC); stable while `i_req` is high.
- i_ack  out  1  one-cycle pulse, fetch complete.
- rdata  out  32  read data; valid in the `d_ack`/`i_ack` cycle.
- sel  out  1  address mux select: 1 = data path, 0 = fetch path.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  write enable; high only together with `mem_en`.
- mem_addr  out  32  registered memory address.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  memory read data.
- busy  out  1  high in every state except IDLE.

## Operation

- Reset (asynchronous on `rst_n` low) sets state to IDLE, the starvation counter to 0 and every output to 0: `sel`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`, `d_ack`, `i_ack` and `busy`.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:** sample requests.
  - Only one request high: that requester wins.
  - Both high: data wins unless the starvation counter equals STARVE_MAX, in which case fetch wins.
  - On a grant, register the winner's address into `mem_addr`. For a data grant, also register `d_wdata` into `mem_wdata` and `d_we` into a write flag. For a fetch grant, the write flag is 0.
  - On a grant, set `sel` (1 = data, 0 = fetch) and go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE** (1 cycle): `mem_en` = 1 and `mem_we` = write flag. Load the wait counter with MEM_LAT, then go to WAIT.
- **WAIT** (MEM_LAT cycles): decrement the wait counter. In the last WAIT cycle, capture `mem_rdata` into `rdata`, but only for reads. Writes leave `rdata` unchanged. Then go to RESP.
- **RESP** (1 cycle): pulse the ack of the granted requester, then go to IDLE. The ack is never asserted for the other requester.
- `mem_addr`, `mem_wdata` and `sel` hold their values from the grant until the next grant. They do not change in IDLE.
- Starvation counter, updated at each grant:
  - Data granted while `i_req` is high: increment, saturating at STARVE_MAX.
  - Fetch granted, or data granted while `i_req` is low: clear to 0.
- Requests are ignored outside IDLE. Request or address changes in mid-transaction have no effect.

## Timing

- A request sampled in IDLE at cycle 0 gives: ISSUE in cycle 1, valid `mem_rdata` in cycle 1+MEM_LAT, and ack with `rdata` in cycle MEM_LAT+2.
- Back-to-back throughput is one access per MEM_LAT+3 cycles. A requester keeping `req` high after its ack starts a new access at the next IDLE cycle.
- Requesters deassert `req` in the cycle after ack unless they want another access.
- Simultaneous requests in IDLE are resolved by the priority and starvation rule only. There is no tie ambiguity.
- Reset asserted mid-transaction abandons the access. No ack is issued and `mem_en` drops immediately.

## Test plan

- Reset, then a single fetch: `i_req`=1, `i_addr`=0x0000_0010, MEM_LAT=2, `mem_rdata`=0xDEAD_BEEF in cycle 3 -> `sel`=0, `mem_en` in cycle 1 only, `i_ack` with `rdata`=0xDEAD_BEEF in cycle 4, `d_ack` never asserted.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0x1234_5678 -> in cycle 1 `mem_en`=`mem_we`=1, `mem_addr`=0x100, `mem_wdata`=0x1234_5678; `d_ack` in cycle 4; `rdata` keeps its previous value.
- Both requesters held high continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; `sel` tracks each grant.
- `i_req` low during data grants, then raised -> data still wins while both are high until 4 consecutive contended data grants have been made.
- `rst_n` pulsed low during WAIT -> all outputs 0 asynchronously, no ack, and the next request completes with the normal MEM_LAT+2 latency.
- MEM_LAT=1 build -> ack in cycle 3; `mem_we` never high without `mem_en`.
